// File: rtl/shiftreg_responder.sv
// Responder end of the button shift-register link: loads a parallel button word
// and shifts it out MSB first on synchronised rising edges of the controller's shift clock.
module shiftreg_responder #(
  parameter int WIDTH       = 16,
  parameter bit INVERT      = 1'b1,
  parameter bit SERIAL_FILL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shiftreg_clk,
  input  logic                       shiftreg_loadn,
  input  logic [WIDTH-1:0]           buttons_in,
  output logic                       shiftreg_out,
  output logic [$clog2(WIDTH+1)-1:0] shift_count,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic clkSync1_q, clkSync2_q, clkDly_q;
  logic loadnSync1_q, loadnSync2_q;
  logic clkRise;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    shiftCount_q, shiftCount_d;
  logic             frameDone_q, frameDone_d;
  logic             overrun_q, overrun_d;

  // Loadn idles high so a reset link does not look like a load in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkSync1_q   <= 1'b0;
      clkSync2_q   <= 1'b0;
      clkDly_q     <= 1'b0;
      loadnSync1_q <= 1'b1;
      loadnSync2_q <= 1'b1;
    end else begin
      clkSync1_q   <= shiftreg_clk;
      clkSync2_q   <= clkSync1_q;
      clkDly_q     <= clkSync2_q;
      loadnSync1_q <= shiftreg_loadn;
      loadnSync2_q <= loadnSync1_q;
    end
  end

  assign clkRise = clkSync2_q & ~clkDly_q;

  // Load is level-sensitive and masks any shift edge seen while it is held
  always_comb begin
    sr_d         = sr_q;
    shiftCount_d = shiftCount_q;
    overrun_d    = overrun_q;
    frameDone_d  = 1'b0;
    if (!loadnSync2_q) begin
      sr_d         = buttons_in ^ {WIDTH{INVERT}};
      shiftCount_d = '0;
      overrun_d    = 1'b0;
    end else if (clkRise) begin
      sr_d = {sr_q[WIDTH-2:0], SERIAL_FILL};
      if (shiftCount_q == FULL) begin
        overrun_d = 1'b1;
      end else begin
        shiftCount_d = shiftCount_q + 1'b1;
        frameDone_d  = (shiftCount_q == LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= {WIDTH{INVERT}};
      shiftCount_q <= '0;
      frameDone_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      shiftCount_q <= shiftCount_d;
      frameDone_q  <= frameDone_d;
      overrun_q    <= overrun_d;
    end
  end

  assign shiftreg_out = sr_q[WIDTH-1];
  assign shift_count  = shiftCount_q;
  assign frame_done   = frameDone_q;
  assign overrun      = overrun_q;

endmodule
